gshare_branch_predictor: RTL
============================

Name: gshare_branch_predictor

Overview:
- Parametrised next-generation branch predictor for the RV64 fetch stage.
- Combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of 2-bit saturating counters.
- MODE selects bimodal or gshare (PC XOR global history) PHT indexing.
- Fetch performs a same-cycle lookup on `pc`; execute updates the tables with resolved outcomes one cycle later.

Parameters:
- ADDR_W, 64, width of all PC and target addresses.
- BTB_ENTRIES, 64, number of BTB entries; power of two, at least 2.
- PHT_ENTRIES, 256, number of 2-bit counters; power of two, at least 2.
- GHR_W, 8, global history register width; GHR_W <= log2(PHT_ENTRIES).
- MODE, 1, 0 = bimodal (PC-only index), 1 = gshare (PC XOR GHR index).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- pc  in  ADDR_W  fetch-stage PC to predict.
- pred_taken  out  1  predict redirect to `target`.
- target  out  ADDR_W  predicted target; 0 when BTB misses.
- btb_hit  out  1  valid BTB entry whose tag matches `pc`.
- branch  in  1  update strobe: resolved conditional branch.
- jump  in  1  update strobe: resolved unconditional jump (JAL/JALR).
- old_pc  in  ADDR_W  PC of the resolved instruction.
- next_pc  in  ADDR_W  resolved target address of that instruction.
- jump_taken  in  1  actual outcome; ignored when `jump` = 1 (treated as taken).
- ghr_out  out  GHR_W  current global history, for debug and verification.

Behaviour:
- **Index and tag fields**
  - BTB index = pc[2+BI-1:2], with BI = log2(BTB_ENTRIES).
  - BTB tag = pc[ADDR_W-1:2+BI].
  - PHT base index = pc[2+PI-1:2], with PI = log2(PHT_ENTRIES).
  - MODE = 1: the low GHR_W bits of the base index are XORed with GHR. MODE = 0: GHR is ignored for indexing.
- **BTB entry contents:** valid, tag, target[ADDR_W-1:0], is_jump.
- **Lookup (combinational, zero latency)**
  - btb_hit = valid && tag match.
  - pred_taken = btb_hit && (is_jump || counter[1]).
  - target = entry target on hit, else 0.
  - Lookup reads registered state only. An update in the same cycle is not bypassed: lookup sees pre-update values.
- **Update (takes effect at the next CLK edge), when `branch` or `jump` is high**
  - Effective taken t = jump | jump_taken.
  - PHT: only when `branch` = 1 and `jump` = 0. Counter at the index computed from old_pc and the current GHR increments if t, else decrements.
  - Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
  - BTB when t = 1: write valid = 1, tag(old_pc), target = next_pc, is_jump = `jump` at the old_pc index. This overwrites any prior occupant (no replacement policy).
  - BTB when t = 0: the entry is left untouched.
  - GHR: only when `branch` = 1 and `jump` = 0. GHR <= {GHR[GHR_W-2:0], t}. Update is non-speculative (resolved outcomes only).
  - `branch` and `jump` both high: treated as a jump. No PHT or GHR update; BTB written with is_jump = 1.
- **Reset (RST high at a CLK edge)**
  - All BTB valid bits = 0.
  - All PHT counters = 2'b01 (weakly not-taken).
  - GHR = 0.
  - Outputs after reset: pred_taken = 0, btb_hit = 0, target = 0, ghr_out = 0.
  - RST takes priority over a coincident update; that update is discarded.
  - Reset mid-operation drops all learned state.
- **Aliasing:** PHT and BTB index collisions are permitted. Two PCs sharing a BTB index evict each other.
- **Misaligned PCs:** pc[1:0] is ignored.
- **Latency:** prediction 0 cycles; update visible to lookup 1 cycle after the strobe.

Test Plan:
1. **Reset state.** Assert RST for 2 cycles, then lookup pc=0x1000 -> btb_hit=0, pred_taken=0, target=0, ghr_out=0.
2. **Counter training.**
   - MODE=0. Resolve branch at old_pc=0x1000, next_pc=0x1040, jump_taken=1 once, then lookup 0x1000 -> btb_hit=1, target=0x1040, pred_taken=1 (counter 01->10).
   - Then 2 not-taken updates -> pred_taken=0 (counter 00), btb_hit stays 1.
3. **Saturation.** MODE=0. 5 taken updates at 0x2000 then 1 not-taken -> pred_taken still 1 (counter 11->10).
4. **Jump and simultaneous lookup.**
   - jump=1 at old_pc=0x3000, next_pc=0x8000, with lookup pc=0x3000 in the same cycle -> pred_taken=0 that cycle.
   - Next cycle -> pred_taken=1, target=0x8000. ghr_out unchanged.
5. **Gshare history.**
   - MODE=1, GHR_W=8. Branch outcomes T,N,T,T -> ghr_out=8'b00001011.
   - PHT updates land at index pc-field XOR previous GHR; check via lookup alternation on pc=0x4000.
6. **BTB conflict and reset priority.**
   - Taken branches at 0x1000 and 0x1000+4·BTB_ENTRIES -> the first lookup then misses.
   - Update coincident with RST -> no state change after reset.

Source files
------------

// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if: fetch lookup and execute update bundle for the branch predictor
interface gshare_branch_predictor_if #(
  parameter int ADDR_W = 64,
  parameter int GHR_W  = 8
);
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] target;
  logic              btb_hit;
  logic              branch;
  logic              jump;
  logic [ADDR_W-1:0] old_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              jump_taken;
  logic [GHR_W-1:0]  ghr_out;
  modport master (
    output pc, branch, jump, old_pc, next_pc, jump_taken,
    input  pred_taken, target, btb_hit, ghr_out
  );
  modport slave (
    input  pc, branch, jump, old_pc, next_pc, jump_taken,
    output pred_taken, target, btb_hit, ghr_out
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: direct-mapped BTB plus 2-bit counter PHT with bimodal or gshare indexing
module gshare_branch_predictor #(
  parameter int ADDR_W      = 64,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_W       = 8,
  parameter int MODE        = 1
) (
  input logic CLK,
  input logic RST,
  gshare_branch_predictor_if.slave bus
);
  localparam int BI = $clog2(BTB_ENTRIES);
  localparam int PI = $clog2(PHT_ENTRIES);
  localparam int TW = ADDR_W - 2 - BI;
  logic [BTB_ENTRIES-1:0] valid;
  logic [BTB_ENTRIES-1:0] jmp_mem;
  logic [TW-1:0]          tag_mem [BTB_ENTRIES];
  logic [ADDR_W-1:0]      tgt_mem [BTB_ENTRIES];
  logic [1:0]             pht     [PHT_ENTRIES];
  logic [GHR_W-1:0]       ghr;
  logic [BI-1:0]          li, ui;
  logic [PI-1:0]          lp, up;
  logic [1:0]             cnt;
  logic                   t, upd_pht, upd_btb;
  logic                   unused_lsb;
  // gshare folds history into the low index bits; bimodal uses the PC field alone
  function automatic logic [PI-1:0] pidx(input logic [ADDR_W-1:0] a, input logic [GHR_W-1:0] h);
    return a[2+:PI] ^ (MODE != 0 ? PI'(h) : PI'(0));
  endfunction
  assign unused_lsb = ^{bus.pc[1:0], bus.old_pc[1:0]};
  assign li = bus.pc[2+:BI];
  assign lp = pidx(bus.pc, ghr);
  assign ui = bus.old_pc[2+:BI];
  assign up = pidx(bus.old_pc, ghr);
  assign t = bus.jump | bus.jump_taken;
  assign upd_pht = bus.branch & ~bus.jump;
  assign upd_btb = (bus.branch | bus.jump) & t;
  assign cnt = pht[up];
  assign bus.ghr_out = ghr;
  // zero-latency lookup from registered state only; same-cycle updates are not bypassed
  always_comb begin
    bus.btb_hit = valid[li] && tag_mem[li] == bus.pc[2+BI+:TW];
    bus.pred_taken = bus.btb_hit && (jmp_mem[li] || pht[lp][1]);
    bus.target = bus.btb_hit ? tgt_mem[li] : '0;
  end
  // resolved-outcome training of counters, history and BTB; reset wins over a coincident update
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      ghr <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else begin
      if (upd_pht) begin
        pht[up] <= t ? (cnt == 2'b11 ? cnt : cnt + 2'd1) : (cnt == 2'b00 ? cnt : cnt - 2'd1);
        ghr <= GHR_W'({ghr, t});
      end
      if (upd_btb) begin
        valid[ui] <= 1'b1;
        jmp_mem[ui] <= bus.jump;
        tag_mem[ui] <= bus.old_pc[2+BI+:TW];
        tgt_mem[ui] <= bus.next_pc;
      end
    end
  end
endmodule
